// File: rtl/soil_moisture_fsm.sv
// ============================================================================
//  Module      : soil_moisture_fsm
//  Description : Irrigation pump controller; measures soil moisture, waters in
//                fixed bursts with soak periods, and faults on sensor timeout
//                or on too many bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soil_moisture_fsm #(
    parameter int PUMP_CYCLES  = 8,
    parameter int SOAK_CYCLES  = 4,
    parameter int MEAS_TIMEOUT = 16,
    parameter int MAX_BURSTS   = 3,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic measurement_done,
    input  logic moisture_low,
    output logic pump_on,
    output logic measure_req,
    output logic busy,
    output logic fault
);

    localparam int c_BURST_W = $clog2(MAX_BURSTS + 1);

    localparam logic [CNT_W-1:0]     c_MEAS_LAST  = CNT_W'(MEAS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     c_PUMP_LAST  = CNT_W'(PUMP_CYCLES - 1);
    localparam logic [CNT_W-1:0]     c_SOAK_LAST  = CNT_W'(SOAK_CYCLES - 1);
    localparam logic [c_BURST_W-1:0] c_MAX_BURSTS = c_BURST_W'(MAX_BURSTS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEASURE = 3'd1,
        S_CHECK   = 3'd2,
        S_WATER   = 3'd3,
        S_SOAK    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [c_BURST_W-1:0] r_bursts;
    logic [c_BURST_W-1:0] w_bursts_nxt;
    logic                 r_fault;
    logic                 w_fault_nxt;
    logic                 r_pump_on;
    logic                 r_measure_req;
    logic                 r_busy;

    // Next-state logic; every transition into a new state clears the counter.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bursts_nxt = r_bursts;
        w_fault_nxt  = r_fault;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_MEASURE;
                    w_cnt_nxt    = '0;
                    w_bursts_nxt = '0;
                    w_fault_nxt  = 1'b0;
                end
            end

            S_MEASURE: begin
                // A done strobe wins over a timeout landing in the same cycle.
                if (measurement_done) begin
                    w_state_nxt = S_CHECK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_MEAS_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_CHECK: begin
                w_cnt_nxt = '0;
                if (!moisture_low) begin
                    w_state_nxt = S_IDLE;
                end else if (r_bursts >= c_MAX_BURSTS) begin
                    w_state_nxt = S_IDLE;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_state_nxt  = S_WATER;
                    w_bursts_nxt = r_bursts + 1'b1;
                end
            end

            S_WATER: begin
                if (r_cnt == c_PUMP_LAST) begin
                    w_state_nxt = S_SOAK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_SOAK: begin
                if (r_cnt == c_SOAK_LAST) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bursts <= '0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bursts <= w_bursts_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    // Outputs are registered from the next state so they track the state
    // register exactly without a decode stage on the output pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pump_on     <= 1'b0;
            r_measure_req <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_pump_on     <= (w_state_nxt == S_WATER);
            r_measure_req <= (w_state_nxt == S_MEASURE);
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    assign pump_on     = r_pump_on;
    assign measure_req = r_measure_req;
    assign busy        = r_busy;
    assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_soil_moisture_fsm.sv
// ============================================================================
//  Module      : tb_soil_moisture_fsm
//  Description : Scoreboard bench for soil_moisture_fsm; a phase-level model
//                queues expected outputs per cycle, a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soil_moisture_fsm;

    localparam int PUMP = 8;
    localparam int SOAK = 4;
    localparam int TMO  = 16;
    localparam int MAXB = 3;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic measurement_done;
    logic moisture_low;
    logic pump_on;
    logic measure_req;
    logic busy;
    logic fault;

    soil_moisture_fsm #(
        .PUMP_CYCLES  (PUMP),
        .SOAK_CYCLES  (SOAK),
        .MEAS_TIMEOUT (TMO),
        .MAX_BURSTS   (MAXB),
        .CNT_W        (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .measurement_done (measurement_done),
        .moisture_low     (moisture_low),
        .pump_on          (pump_on),
        .measure_req      (measure_req),
        .busy             (busy),
        .fault            (fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pump;
        logic req;
        logic busy;
        logic fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic m_fault;

    function automatic exp_t mk(input logic p, input logic r, input logic b, input logic f);
        mk = {p, r, b, f};
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected output shapes of each phase of the controller.
    function automatic exp_t e_idle(input logic f); return mk(1'b0, 1'b0, 1'b0, f); endfunction
    function automatic exp_t e_meas();  return mk(1'b0, 1'b1, 1'b1, 1'b0); endfunction
    function automatic exp_t e_quiet(); return mk(1'b0, 1'b0, 1'b1, 1'b0); endfunction
    function automatic exp_t e_water(); return mk(1'b1, 1'b0, 1'b1, 1'b0); endfunction

    // Apply one cycle of inputs and queue the outputs expected after that edge.
    task automatic drive(input logic s, input logic d, input logic l, input exp_t e);
        @(negedge clk);
        #1;
        start            = s;
        measurement_done = d;
        moisture_low     = l;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [3:0] got, input logic [3:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: pump/req/busy/fault got %b required %b", name, got, req);
        end
    endtask

    // One start-to-IDLE sequence. dly<0 picks a random done delay per
    // measurement (>=TMO means no done at all); low_mode<0 picks moisture randomly.
    task automatic run_sequence(input int dly, input int low_mode, input int idle_cycles);
        int   bursts;
        int   d;
        bit   fin;
        logic low;
        repeat (idle_cycles) drive(1'b0, rbit(), rbit(), e_idle(m_fault));
        drive(1'b1, rbit(), rbit(), e_meas());
        m_fault = 1'b0;
        bursts  = 0;
        fin     = 1'b0;
        while (!fin) begin
            d = (dly >= 0) ? dly : int'($urandom_range(0, TMO + 3));
            if (d >= TMO) begin
                for (int k = 0; k < TMO; k++)
                    drive(rbit(), 1'b0, rbit(), (k == TMO - 1) ? e_idle(1'b1) : e_meas());
                m_fault = 1'b1;
                fin     = 1'b1;
            end else begin
                for (int k = 0; k < d; k++) drive(rbit(), 1'b0, rbit(), e_meas());
                drive(rbit(), 1'b1, rbit(), e_quiet());
                low = (low_mode < 0) ? logic'($urandom_range(0, 3) != 0) : logic'(low_mode != 0);
                if (!low) begin
                    drive(rbit(), rbit(), 1'b0, e_idle(1'b0));
                    fin = 1'b1;
                end else if (bursts == MAXB) begin
                    drive(rbit(), rbit(), 1'b1, e_idle(1'b1));
                    m_fault = 1'b1;
                    fin     = 1'b1;
                end else begin
                    bursts++;
                    drive(rbit(), rbit(), 1'b1, e_water());
                    for (int k = 0; k < PUMP; k++)
                        drive(rbit(), rbit(), rbit(), (k == PUMP - 1) ? e_quiet() : e_water());
                    for (int k = 0; k < SOAK; k++)
                        drive(rbit(), rbit(), rbit(), (k == SOAK - 1) ? e_meas() : e_quiet());
                end
            end
        end
    endtask

    // Reset pulled low during the third WATER cycle while start keeps pulsing.
    task automatic reset_in_water();
        drive(1'b0, 1'b0, 1'b0, e_idle(m_fault));
        drive(1'b1, 1'b0, 1'b0, e_meas());
        m_fault = 1'b0;
        drive(1'b0, 1'b1, 1'b0, e_quiet());
        drive(1'b0, 1'b0, 1'b1, e_water());
        drive(1'b1, 1'b0, 1'b0, e_water());
        drive(1'b1, 1'b1, 1'b1, e_water());
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_now("async_reset_in_water", {pump_on, measure_req, busy, fault}, 4'b0000);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check_now("held_in_reset", {pump_on, measure_req, busy, fault}, 4'b0000);
        #1;
        reset = 1'b1;
        start = 1'b0;
        drive(1'b0, 1'b1, 1'b1, e_idle(1'b0));
    endtask

    // Monitor: every cycle the DUT presents a new output word; compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({pump_on, measure_req, busy, fault} !== e) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t: pump/req/busy/fault got %b required %b",
                             $time, {pump_on, measure_req, busy, fault}, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        measurement_done = 1'b0;
        moisture_low     = 1'b0;
        m_fault          = 1'b0;
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_now("reset_state", {pump_on, measure_req, busy, fault}, 4'b0000);
        #1;
        reset = 1'b1;

        run_sequence(3, 0, 2);         // wet soil: straight back to IDLE
        run_sequence(1, 1, 1);         // dry soil forever: three bursts then fault
        run_sequence(TMO, -1, 1);      // sensor never answers: timeout fault
        run_sequence(0, 0, 0);         // start clears the fault; done on first cycle
        run_sequence(TMO - 1, 0, 1);   // done on the last cycle beats the timeout
        reset_in_water();
        for (int i = 0; i < 40; i++)
            run_sequence(-1, -1, int'($urandom_range(0, 3)));

        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
